// File: rtl/jamma_pkg.sv
// rtl/jamma_pkg.sv - shared types and constants for the JAMMA joystick scanner
package jamma_pkg;

    typedef enum logic [1:0] {
        SETTLE1,
        SAMP1,
        SETTLE2,
        SAMP2
    } scan_state_e;

    typedef enum logic [2:0] {
        JOY_UP    = 3'd0,
        JOY_DOWN  = 3'd1,
        JOY_LEFT  = 3'd2,
        JOY_RIGHT = 3'd3,
        JOY_FIRE1 = 3'd4,
        JOY_FIRE2 = 3'd5,
        JOY_START = 3'd7
    } joy_bit_e;

    localparam logic [7:0] JOY_IDLE = 8'hFF;

    // Active-low merge: the on-board stick only drives the direction/fire bits.
    function automatic logic [7:0] merge_p1(input logic [7:0] bus, input logic [5:0] onboard);
        logic [7:0] m;
        m = JOY_IDLE;
        for (int i = int'(JOY_UP); i <= int'(JOY_FIRE2); i++) begin
            m[i] = onboard[i];
        end
        return bus & m;
    endfunction

endpackage

// File: rtl/bit_debounce.sv
// rtl/bit_debounce.sv - per-bit sample-gated debouncer, output follows after CNT differing samples
module bit_debounce
    import jamma_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_en_i,
    input  logic [WIDTH-1:0] sample_i,
    output logic [WIDTH-1:0] level_o
);

    logic [WIDTH-1:0] level_q, level_d;
    logic [3:0]       cnt_q [WIDTH];
    logic [3:0]       cnt_d [WIDTH];

    always_comb begin
        level_d = level_q;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sample_en_i) begin
                if (sample_i[b] == level_q[b]) begin
                    cnt_d[b] = 4'd0;
                end else if (cnt_q[b] >= 4'(CNT - 1)) begin
                    level_d[b] = sample_i[b];
                    cnt_d[b]   = 4'd0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '1;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= 4'd0;
            end
        end else begin
            level_q <= level_d;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/jamma_joy_scanner.sv
// rtl/jamma_joy_scanner.sv - multiplexed JAMMA joystick scanner with debounce and coin stretching
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DEBOUNCE_CNT  = 4,
    parameter int COIN_MIN_LEN  = 64
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] JJOY,
    input  logic [1:0] JCOIN,
    input  logic [5:0] JOYSTICK,
    output logic       JSELECT,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_tick
);

    localparam int COIN_WIN = DEBOUNCE_CNT * SETTLE_CYCLES;

    logic [7:0] jjoy_s1_q, jjoy_s2_q;
    logic [1:0] jcoin_s1_q, jcoin_s2_q;
    logic [5:0] joy_s1_q, joy_s2_q;

    scan_state_e state_q;
    logic [7:0]  cnt_q;
    logic        jsel_q;
    logic        tick_q;

    logic [1:0]        coin_deb_q, coin_deb_d;
    logic [1:0]        coin_q, coin_d;
    logic [1:0][11:0]  coin_cnt_q, coin_cnt_d;
    logic [1:0][15:0]  stretch_q, stretch_d;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            jjoy_s1_q  <= '1;
            jjoy_s2_q  <= '1;
            jcoin_s1_q <= '1;
            jcoin_s2_q <= '1;
            joy_s1_q   <= '1;
            joy_s2_q   <= '1;
        end else begin
            jjoy_s1_q  <= JJOY;
            jjoy_s2_q  <= jjoy_s1_q;
            jcoin_s1_q <= JCOIN;
            jcoin_s2_q <= jcoin_s1_q;
            joy_s1_q   <= JOYSTICK;
            joy_s2_q   <= joy_s1_q;
        end
    end

    // Select flips on the edge entering each settle phase so the bus has the full window to settle.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= SETTLE1;
            cnt_q   <= 8'd0;
            jsel_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                SETTLE1, SETTLE2: begin
                    if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= 8'd0;
                        state_q <= (state_q == SETTLE1) ? SAMP1 : SAMP2;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SAMP1: begin
                    cnt_q   <= 8'd0;
                    jsel_q  <= 1'b1;
                    state_q <= SETTLE2;
                end
                SAMP2: begin
                    cnt_q   <= 8'd0;
                    jsel_q  <= 1'b0;
                    tick_q  <= 1'b1;
                    state_q <= SETTLE1;
                end
                default: state_q <= SETTLE1;
            endcase
        end
    end

    bit_debounce #(.WIDTH(8), .CNT(DEBOUNCE_CNT)) u_deb_p1 (
        .clk_i       (pclk),
        .rst_i       (reset),
        .sample_en_i (state_q == SAMP1),
        .sample_i    (merge_p1(jjoy_s2_q, joy_s2_q)),
        .level_o     (joystick1)
    );

    bit_debounce #(.WIDTH(8), .CNT(DEBOUNCE_CNT)) u_deb_p2 (
        .clk_i       (pclk),
        .rst_i       (reset),
        .sample_en_i (state_q == SAMP2),
        .sample_i    (jjoy_s2_q),
        .level_o     (joystick2)
    );

    // Hold only starts from a high output, so a re-fall during the hold cannot extend it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            coin_deb_d[i] = coin_deb_q[i];
            coin_cnt_d[i] = coin_cnt_q[i];
            stretch_d[i]  = stretch_q[i];
            coin_d[i]     = coin_q[i];
            if (jcoin_s2_q[i] == coin_deb_q[i]) begin
                coin_cnt_d[i] = 12'd0;
            end else if (coin_cnt_q[i] >= 12'(COIN_WIN - 1)) begin
                coin_deb_d[i] = jcoin_s2_q[i];
                coin_cnt_d[i] = 12'd0;
            end else begin
                coin_cnt_d[i] = coin_cnt_q[i] + 12'd1;
            end
            if (coin_deb_q[i] && !coin_deb_d[i] && coin_q[i]) begin
                coin_d[i]    = 1'b0;
                stretch_d[i] = 16'(COIN_MIN_LEN - 1);
            end else if (stretch_q[i] != 16'd0) begin
                coin_d[i]    = 1'b0;
                stretch_d[i] = stretch_q[i] - 16'd1;
            end else begin
                coin_d[i] = coin_deb_d[i];
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            coin_deb_q <= 2'b11;
            coin_q     <= 2'b11;
            coin_cnt_q <= '0;
            stretch_q  <= '0;
        end else begin
            coin_deb_q <= coin_deb_d;
            coin_q     <= coin_d;
            coin_cnt_q <= coin_cnt_d;
            stretch_q  <= stretch_d;
        end
    end

    assign JSELECT   = jsel_q;
    assign coin      = coin_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// tb/tb_jamma_joy_scanner.sv - scoreboard bench for jamma_joy_scanner
module tb_jamma_joy_scanner;

    localparam int S    = 16;
    localparam int D    = 4;
    localparam int L    = 300;
    localparam int P    = 2 * (S + 1);
    localparam int W    = D * S;
    localparam int MAXC = 20000;

    logic       pclk  = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] p1_drv = 8'hFF;
    logic [7:0] p2_drv = 8'hFF;
    logic [5:0] joy_drv = 6'h3F;
    logic [1:0] coin_drv = 2'b11;

    logic [7:0] JJOY;
    logic       JSELECT;
    logic [7:0] joystick1, joystick2;
    logic [1:0] coin;
    logic       scan_tick;

    // Adapter board: the bus shows whichever player JSELECT points at.
    assign JJOY = JSELECT ? p2_drv : p1_drv;

    always #5 pclk = ~pclk;

    jamma_joy_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CNT(D), .COIN_MIN_LEN(L)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .JJOY      (JJOY),
        .JCOIN     (coin_drv),
        .JOYSTICK  (joy_drv),
        .JSELECT   (JSELECT),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .coin      (coin),
        .scan_tick (scan_tick)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] p1_h [MAXC];
    logic [7:0] p2_h [MAXC];
    logic [5:0] joy_h [MAXC];
    logic [1:0] coin_h [MAXC];
    int t;

    logic [7:0] m_j1, m_j2, m_deb, m_coin;
    int         m_tf [2];
    logic [7:0] w1 [$];
    logic [7:0] w2 [$];
    logic [7:0] wc [$];

    typedef struct packed {
        logic       jsel;
        logic       tick;
        logic [1:0] coin;
    } cyc_t;
    cyc_t        cyc_q [$];
    logic [15:0] scan_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // A bit flips once the last n samples all disagree with the current level.
    function automatic logic [7:0] settle_bits(input logic [7:0] win [$], input int n, input logic [7:0] cur);
        logic [7:0] r;
        r = cur;
        if (win.size() < n) return r;
        for (int b = 0; b < 8; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = 0; k < n; k++) begin
                if (win[k][b] == cur[b]) all_diff = 1'b0;
            end
            if (all_diff) r[b] = ~cur[b];
        end
        return r;
    endfunction

    task automatic model_reset();
        t      = 0;
        m_j1   = 8'hFF;
        m_j2   = 8'hFF;
        m_deb  = 8'hFF;
        m_coin = 8'hFF;
        m_tf[0] = -1;
        m_tf[1] = -1;
        w1.delete();
        w2.delete();
        wc.delete();
        cyc_q.delete();
        scan_q.delete();
    endtask

    task automatic model_edge();
        int         p;
        logic [7:0] v;
        logic [7:0] old;
        cyc_t       c;
        p = (t - 1) % P;
        if (p == S) begin
            v = (t >= 3) ? (p1_h[t-2] & {2'b11, joy_h[t-2]}) : 8'hFF;
            w1.push_back(v);
            if (w1.size() > D) void'(w1.pop_front());
            m_j1 = settle_bits(w1, D, m_j1);
        end
        if (p == 2 * S + 1) begin
            v = (t >= 3) ? p2_h[t-2] : 8'hFF;
            w2.push_back(v);
            if (w2.size() > D) void'(w2.pop_front());
            m_j2 = settle_bits(w2, D, m_j2);
            scan_q.push_back({m_j1, m_j2});
        end
        v = (t >= 3) ? {6'h3F, coin_h[t-2]} : 8'hFF;
        wc.push_back(v);
        if (wc.size() > W) void'(wc.pop_front());
        old   = m_deb;
        m_deb = settle_bits(wc, W, m_deb);
        for (int i = 0; i < 2; i++) begin
            if (old[i] && !m_deb[i] && m_coin[i]) m_tf[i] = t;
            m_coin[i] = (m_tf[i] >= 0 && (t - m_tf[i]) < L) ? 1'b0 : m_deb[i];
        end
        c.jsel = ((t % P) >= S + 1);
        c.tick = (p == 2 * S + 1);
        c.coin = m_coin[1:0];
        cyc_q.push_back(c);
    endtask

    task automatic step();
        t++;
        p1_h[t]   = p1_drv;
        p2_h[t]   = p2_drv;
        joy_h[t]  = joy_drv;
        coin_h[t] = coin_drv;
        @(posedge pclk);
        #1;
        model_edge();
    endtask

    function automatic logic [7:0] rand_word();
        return ~($urandom() & $urandom() & $urandom());
    endfunction

    initial begin
        cyc_t        c;
        logic [15:0] sj;
        forever begin
            @(negedge pclk);
            if (!reset && cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("jsel_tick_coin", {28'd0, JSELECT, scan_tick, coin}, {28'd0, c});
                if (scan_tick) begin
                    if (scan_q.size() == 0) begin
                        check("scan_tick_unexpected", 32'd1, 32'd0);
                    end else begin
                        sj = scan_q.pop_front();
                        check("joysticks", {16'd0, joystick1, joystick2}, {16'd0, sj});
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] keep;
        int         n;
        model_reset();
        repeat (3) @(posedge pclk);
        #2;
        check("rst_jsel", {31'd0, JSELECT}, 32'd0);
        check("rst_j1", {24'd0, joystick1}, 32'hFF);
        check("rst_j2", {24'd0, joystick2}, 32'hFF);
        check("rst_coin", {30'd0, coin}, 32'd3);
        check("rst_tick", {31'd0, scan_tick}, 32'd0);
        reset = 1'b0;

        repeat (2 * P) step();

        p1_drv = 8'hFE;
        repeat (5 * P) step();
        p1_drv = 8'hFF;
        repeat (5 * P) step();

        joy_drv = 6'h3B;
        repeat (5 * P) step();
        joy_drv = 6'h3F;
        repeat (5 * P) step();

        while (((t - 1) % P) != S) step();
        p1_drv = 8'hF7;
        repeat (3 * P) step();
        p1_drv = 8'hFF;
        repeat (3 * P) step();

        coin_drv[1] = 1'b0;
        repeat (70) step();
        repeat (10) begin
            coin_drv[1] = ~coin_drv[1];
            step();
        end
        coin_drv[1] = 1'b1;
        repeat (L + 100) step();

        coin_drv[0] = 1'b0;
        repeat (70) step();
        coin_drv[0] = 1'b1;
        repeat (70) step();
        coin_drv[0] = 1'b0;
        repeat (70) step();
        coin_drv[0] = 1'b1;
        repeat (L + 100) step();

        repeat (40) begin
            p1_drv   = rand_word();
            p2_drv   = rand_word();
            joy_drv  = rand_word()[5:0];
            coin_drv = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b11;
            n = $urandom_range(20, 220);
            repeat (n) begin
                if ($urandom_range(0, 39) == 0) begin
                    keep = p1_drv;
                    p1_drv[$urandom_range(0, 7)] ^= 1'b1;
                    step();
                    p1_drv = keep;
                end else begin
                    step();
                end
            end
        end

        p1_drv   = 8'hFF;
        joy_drv  = 6'h3F;
        coin_drv = 2'b11;
        p2_drv   = 8'hEF;
        repeat (6 * P) step();
        while (((t - 1) % P) != S + 5) step();
        check("j2_before_reset", {24'd0, joystick2}, {24'd0, m_j2});
        check("model_j2_ef", {24'd0, m_j2}, 32'hEF);
        #3;
        reset = 1'b1;
        cyc_q.delete();
        scan_q.delete();
        #1;
        check("midrst_jsel", {31'd0, JSELECT}, 32'd0);
        check("midrst_j2", {24'd0, joystick2}, 32'hFF);
        check("midrst_j1", {24'd0, joystick1}, 32'hFF);
        check("midrst_tick", {31'd0, scan_tick}, 32'd0);
        repeat (2) @(posedge pclk);
        #2;
        model_reset();
        reset = 1'b0;
        repeat (6 * P) step();

        #10;
        check("queues_drained", cyc_q.size() + scan_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
